// File: rtl/regfile_access_ctrl.sv
// Access controller for a 16x16 register array: scrubs after reset, arbitrates CPU/debug
// requests round-robin, drives one-hot strobes and registers read responses with bypass.
module regfile_access_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit SCRUB_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_valid,
  output logic                cpu_ready,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_waddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [ADDR_W-1:0]   cpu_raddr1,
  input  logic [ADDR_W-1:0]   cpu_raddr2,
  input  logic                dbg_valid,
  output logic                dbg_ready,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic [DATA_W-1:0]   rf_D,
  output logic [NUM_REGS-1:0] rf_WriteReg,
  output logic [NUM_REGS-1:0] rf_RdEn1,
  output logic [NUM_REGS-1:0] rf_RdEn2,
  input  logic [DATA_W-1:0]   rf_Bitline1,
  input  logic [DATA_W-1:0]   rf_Bitline2,
  output logic                rsp_valid,
  output logic                rsp_dbg,
  output logic [DATA_W-1:0]   rsp_data1,
  output logic [DATA_W-1:0]   rsp_data2,
  output logic                scrub_busy
);

  typedef enum logic {ST_SCRUB, ST_RUN} state_t;
  typedef enum logic {GNT_CPU, GNT_DBG} grant_t;

  localparam state_t RESET_STATE = SCRUB_EN ? ST_SCRUB : ST_RUN;

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   scrub_ptr_q, scrub_ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_dbg_q, rsp_dbg_d;
  logic [DATA_W-1:0]   rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0]   rsp_data2_q, rsp_data2_d;
  logic                grant_cpu, grant_dbg;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    in_range = (int'(a) < NUM_REGS);
  endfunction

  // Out-of-range addresses decode to no strobe at all.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = '0;
    if (in_range(a)) onehot[a] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RESET_STATE;
      last_grant_q <= GNT_DBG;
      scrub_ptr_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dbg_q    <= 1'b0;
      rsp_data1_q  <= '0;
      rsp_data2_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      scrub_ptr_q  <= scrub_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dbg_q    <= rsp_dbg_d;
      rsp_data1_q  <= rsp_data1_d;
      rsp_data2_q  <= rsp_data2_d;
    end
  end

  // Outputs are forced quiet while reset is held so no strobe leaks onto the array.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    scrub_ptr_d  = scrub_ptr_q;
    rsp_valid_d  = 1'b0;
    rsp_dbg_d    = 1'b0;
    rsp_data1_d  = rsp_data1_q;
    rsp_data2_d  = rsp_data2_q;
    grant_cpu    = 1'b0;
    grant_dbg    = 1'b0;
    cpu_ready    = 1'b0;
    dbg_ready    = 1'b0;
    rf_D         = '0;
    rf_WriteReg  = '0;
    rf_RdEn1     = '0;
    rf_RdEn2     = '0;

    if (rst) begin
      case (state_q)
        ST_SCRUB: begin
          rf_WriteReg = onehot(scrub_ptr_q);
          scrub_ptr_d = scrub_ptr_q + 1'b1;
          if (scrub_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
            scrub_ptr_d = '0;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          grant_cpu = cpu_valid && (!dbg_valid || (last_grant_q == GNT_DBG));
          grant_dbg = dbg_valid && !grant_cpu;
          cpu_ready = grant_cpu;
          dbg_ready = grant_dbg;

          if (grant_cpu) begin
            last_grant_d = GNT_CPU;
            rf_RdEn1     = onehot(cpu_raddr1);
            rf_RdEn2     = onehot(cpu_raddr2);
            if (cpu_we) begin
              rf_WriteReg = onehot(cpu_waddr);
              rf_D        = cpu_wdata;
            end
            rsp_valid_d = 1'b1;
            rsp_data1_d = '0;
            rsp_data2_d = '0;
            // The array returns the old value this cycle, so forward the write data.
            if (in_range(cpu_raddr1)) begin
              rsp_data1_d = (cpu_we && in_range(cpu_waddr) && (cpu_raddr1 == cpu_waddr))
                            ? cpu_wdata : rf_Bitline1;
            end
            if (in_range(cpu_raddr2)) begin
              rsp_data2_d = (cpu_we && in_range(cpu_waddr) && (cpu_raddr2 == cpu_waddr))
                            ? cpu_wdata : rf_Bitline2;
            end
          end else if (grant_dbg) begin
            last_grant_d = GNT_DBG;
            if (dbg_we) begin
              rf_WriteReg = onehot(dbg_addr);
              rf_D        = dbg_wdata;
            end else begin
              rf_RdEn1    = onehot(dbg_addr);
              rsp_valid_d = 1'b1;
              rsp_dbg_d   = 1'b1;
              rsp_data1_d = in_range(dbg_addr) ? rf_Bitline1 : '0;
              rsp_data2_d = '0;
            end
          end
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_dbg    = rsp_dbg_q;
  assign rsp_data1  = rsp_data1_q;
  assign rsp_data2  = rsp_data2_q;
  assign scrub_busy = (state_q == ST_SCRUB);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: emulates the register array, drives directed and
// random CPU/debug traffic and compares against a register-level reference model.
module tb_regfile_access_ctrl;

   localparam int NumRegs = 16;
   localparam int DataW   = 16;
   localparam int AddrW   = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                cpu_valid, cpu_we, dbg_valid, dbg_we;
   logic [AddrW-1:0]    cpu_waddr, cpu_raddr1, cpu_raddr2, dbg_addr;
   logic [DataW-1:0]    cpu_wdata, dbg_wdata;
   logic                cpu_ready, dbg_ready, rsp_valid, rsp_dbg, scrub_busy;
   logic [DataW-1:0]    rf_D, rsp_data1, rsp_data2, rf_Bitline1, rf_Bitline2;
   logic [NumRegs-1:0]  rf_WriteReg, rf_RdEn1, rf_RdEn2;

   int errorCount = 0;
   int checkCount = 0;

   // Reference model state
   logic [DataW-1:0]    refRegs [NumRegs];
   logic                lastGrantDbg = 1'b1;
   logic                pendValid = 1'b0;
   logic                pendDbg = 1'b0;
   logic [DataW-1:0]    pendData1 = '0;
   logic [DataW-1:0]    pendData2 = '0;
   logic                cpuAccepted = 1'b0;
   logic                dbgAccepted = 1'b0;

   // Emulated register array content, seeded with garbage so the scrub matters
   logic [DataW-1:0]    arrayMem [NumRegs];

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
      .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .cpu_raddr1(cpu_raddr1), .cpu_raddr2(cpu_raddr2),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .rf_D(rf_D), .rf_WriteReg(rf_WriteReg), .rf_RdEn1(rf_RdEn1), .rf_RdEn2(rf_RdEn2),
      .rf_Bitline1(rf_Bitline1), .rf_Bitline2(rf_Bitline2),
      .rsp_valid(rsp_valid), .rsp_dbg(rsp_dbg),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .scrub_busy(scrub_busy)
   );

   // The array latches every enabled row on the rising edge
   always @(posedge clk) begin
      for (int i = 0; i < NumRegs; i++)
         if (rf_WriteReg[i]) arrayMem[i] <= rf_D;
   end

   // Bitlines are the wired-OR of all enabled rows
   always_comb begin
      rf_Bitline1 = '0;
      rf_Bitline2 = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (rf_RdEn1[i]) rf_Bitline1 = rf_Bitline1 | arrayMem[i];
         if (rf_RdEn2[i]) rf_Bitline2 = rf_Bitline2 | arrayMem[i];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cv, input logic cwe, input logic [3:0] cwa,
                                input logic [15:0] cwd, input logic [3:0] cr1,
                                input logic [3:0] cr2, input logic dv, input logic dwe,
                                input logic [3:0] da, input logic [15:0] dwd);
      cpu_valid  = cv;  cpu_we     = cwe; cpu_waddr = cwa; cpu_wdata = cwd;
      cpu_raddr1 = cr1; cpu_raddr2 = cr2;
      dbg_valid  = dv;  dbg_we     = dwe; dbg_addr  = da;  dbg_wdata = dwd;
   endtask

   // One scrub cycle: the k-th register is written with zero, nothing else moves
   task automatic scrubCycle(input int k);
      logic [15:0] one;
      one = 16'h0001;
      @(negedge clk);
      checkOutput($sformatf("scrub_wr%0d", k), 32'(rf_WriteReg), 32'(one << k));
      checkOutput("scrub_D", 32'(rf_D), 32'h0);
      checkOutput("scrub_rden", 32'({rf_RdEn1, rf_RdEn2}), 32'h0);
      checkOutput("scrub_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
      checkOutput("scrub_busy", 32'(scrub_busy), 32'h1);
      @(posedge clk);
      #1;
   endtask

   // One RUN cycle: predict grant, strobes and response from register-level rules
   task automatic runCycle();
      logic        gc, gd, nv, nd;
      logic [15:0] ewr, er1, er2, ed, n1, n2, one;
      one = 16'h0001;
      @(negedge clk);
      gc = 1'b0;
      gd = 1'b0;
      if (cpu_valid && dbg_valid) begin
         if (lastGrantDbg) gc = 1'b1;
         else gd = 1'b1;
      end else if (cpu_valid) gc = 1'b1;
      else if (dbg_valid) gd = 1'b1;
      ewr = '0; er1 = '0; er2 = '0; ed = '0;
      nv = 1'b0; nd = 1'b0; n1 = pendData1; n2 = pendData2;
      if (gc) begin
         er1 = one << cpu_raddr1;
         er2 = one << cpu_raddr2;
         if (cpu_we) begin
            ewr = one << cpu_waddr;
            ed  = cpu_wdata;
         end
         nv = 1'b1;
         n1 = (cpu_we && cpu_raddr1 == cpu_waddr) ? cpu_wdata : refRegs[cpu_raddr1];
         n2 = (cpu_we && cpu_raddr2 == cpu_waddr) ? cpu_wdata : refRegs[cpu_raddr2];
      end else if (gd) begin
         if (dbg_we) begin
            ewr = one << dbg_addr;
            ed  = dbg_wdata;
         end else begin
            er1 = one << dbg_addr;
            nv = 1'b1; nd = 1'b1;
            n1 = refRegs[dbg_addr];
            n2 = '0;
         end
      end
      checkOutput("cpu_ready", 32'(cpu_ready), 32'(gc));
      checkOutput("dbg_ready", 32'(dbg_ready), 32'(gd));
      checkOutput("both_ready", 32'(cpu_ready & dbg_ready), 32'h0);
      checkOutput("rf_WriteReg", 32'(rf_WriteReg), 32'(ewr));
      checkOutput("rf_RdEn1", 32'(rf_RdEn1), 32'(er1));
      checkOutput("rf_RdEn2", 32'(rf_RdEn2), 32'(er2));
      if (ewr != 0) checkOutput("rf_D", 32'(rf_D), 32'(ed));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(pendValid));
      if (pendValid) begin
         checkOutput("rsp_dbg", 32'(rsp_dbg), 32'(pendDbg));
         checkOutput("rsp_data1", 32'(rsp_data1), 32'(pendData1));
         checkOutput("rsp_data2", 32'(rsp_data2), 32'(pendData2));
      end
      checkOutput("run_busy", 32'(scrub_busy), 32'h0);
      @(posedge clk);
      if (gc && cpu_we) refRegs[cpu_waddr] = cpu_wdata;
      if (gd && dbg_we) refRegs[dbg_addr] = dbg_wdata;
      if (gc) lastGrantDbg = 1'b0;
      if (gd) lastGrantDbg = 1'b1;
      pendValid = nv; pendDbg = nd; pendData1 = n1; pendData2 = n2;
      cpuAccepted = gc;
      dbgAccepted = gd;
      #1;
   endtask

   initial begin
      for (int i = 0; i < NumRegs; i++) arrayMem[i] = 16'($urandom);
      applyStimulus(1'b1, 1'b1, 4'd3, 16'hBEEF, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0);

      // Held in reset with a pending CPU request
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
      checkOutput("rst_rsp", 32'({rsp_valid, rsp_dbg}), 32'h0);
      checkOutput("rst_data", 32'({rsp_data1, rsp_data2}), 32'h0);
      checkOutput("rst_strobes", 32'(rf_WriteReg | rf_RdEn1 | rf_RdEn2), 32'h0);
      checkOutput("rst_D", 32'(rf_D), 32'h0);
      checkOutput("rst_busy", 32'(scrub_busy), 32'h1);

      // Abort a scrub part way, then restart from R0
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 8; k++) scrubCycle(k);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_strobes", 32'(rf_WriteReg | rf_RdEn1 | rf_RdEn2), 32'h0);
      checkOutput("abort_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
      checkOutput("abort_busy", 32'(scrub_busy), 32'h1);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < NumRegs; k++) scrubCycle(k);
      for (int i = 0; i < NumRegs; i++) refRegs[i] = '0;

      // Held write to R3, then read R3 on both ports
      runCycle();
      applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0);
      runCycle();
      // Write-to-read bypass
      applyStimulus(1'b1, 1'b1, 4'd5, 16'h1234, 4'd5, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0);
      runCycle();
      // Debug write R7, then debug read R7
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 16'h00A5);
      runCycle();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd7, 16'h0);
      runCycle();
      // CPU-only grant, then contention for four cycles
      applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0);
      runCycle();
      applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd3, 4'd5, 1'b1, 1'b0, 4'd7, 16'h0);
      repeat (4) runCycle();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0);
      runCycle();

      // Random traffic; each requester holds its request until accepted
      cpuAccepted = 1'b1;
      dbgAccepted = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!cpu_valid || cpuAccepted) begin
            cpu_valid = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_waddr = 4'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            cpu_raddr1 = ($urandom_range(0, 1) != 0) ? cpu_waddr : 4'($urandom_range(0, 15));
            cpu_raddr2 = ($urandom_range(0, 2) == 0) ? cpu_waddr : 4'($urandom_range(0, 15));
         end
         if (!dbg_valid || dbgAccepted) begin
            dbg_valid = ($urandom_range(0, 2) == 0);
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = 4'($urandom_range(0, 15));
            dbg_wdata = 16'($urandom);
         end
         runCycle();
      end
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0);
      runCycle();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
